// File: rtl/memory_access.sv
// memory_access
// Load/store unit following the RV32I execute stage. Takes the ALU result as
// an effective address (or a plain passthrough value for non-memory ops) and
// the rs2 store data, runs one valid/ready transaction against data memory and
// returns exactly one response per accepted request.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   req_valid_i/ready_o   request handshake from execute (ready only in IDLE)
//   opcode_i, funct3_i    instruction opcode and access width/sign
//   addr_i                ALU result
//   store_data_i          rs2 value
//   dmem_req_*            memory request: word address, we, strobes, wdata
//   dmem_rsp_valid_i      load data valid (only looked at in WAIT)
//   dmem_rdata_i          load word
//   rsp_valid_o           one-cycle completion pulse
//   rsp_data_o            load result / passthrough value / 0
//   fault_o               misaligned or illegal funct3, qualified by rsp_valid_o
//
// state | meaning
// IDLE  | ready for a request; decode and register it on acceptance
// REQ   | memory request presented, held stable until dmem_req_ready_i
// WAIT  | load issued, waiting for dmem_rsp_valid_i
// DONE  | rsp_valid_o high for this single cycle
module memory_access #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [6:0]        opcode_i,
   input  logic [2:0]        funct3_i,
   input  logic [AWIDTH-1:0] addr_i,
   input  logic [DWIDTH-1:0] store_data_i,
   output logic              dmem_req_valid_o,
   input  logic              dmem_req_ready_i,
   output logic [AWIDTH-1:0] dmem_addr_o,
   output logic              dmem_we_o,
   output logic [3:0]        dmem_wstrb_o,
   output logic [DWIDTH-1:0] dmem_wdata_o,
   input  logic              dmem_rsp_valid_i,
   input  logic [DWIDTH-1:0] dmem_rdata_i,
   output logic              rsp_valid_o,
   output logic [DWIDTH-1:0] rsp_data_o,
   output logic              fault_o
);

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                dmem_req_valid_q, dmem_req_valid_d;
   logic [AWIDTH-1:0]   dmem_addr_q, dmem_addr_d;
   logic                dmem_we_q, dmem_we_d;
   logic [3:0]          dmem_wstrb_q, dmem_wstrb_d;
   logic [DWIDTH-1:0]   dmem_wdata_q, dmem_wdata_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DWIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic                fault_q, fault_d;
   logic [2:0]          funct3_q, funct3_d;
   logic [1:0]          offset_q, offset_d;

   logic                is_load;
   logic                is_store;
   logic                misaligned;
   logic                load_bad;
   logic                store_bad;
   logic                req_fault;
   logic [3:0]          store_strb;
   logic [DWIDTH-1:0]   store_wdata;
   logic [DWIDTH-1:0]   load_shifted;
   logic [DWIDTH-1:0]   load_ext;

   // Request decode (combinational on the incoming request)
   always_comb begin
      is_load    = (opcode_i == OPC_LOAD);
      is_store   = (opcode_i == OPC_STORE);
      misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                   ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
      load_bad   = is_load && ((funct3_i == 3'b011) || (funct3_i == 3'b110) ||
                               (funct3_i == 3'b111));
      store_bad  = is_store && !((funct3_i == 3'b000) || (funct3_i == 3'b001) ||
                                 (funct3_i == 3'b010));
      req_fault  = (is_load || is_store) && (misaligned || load_bad || store_bad);
   end

   // Store lanes: narrow data is replicated so every lane carries it and the
   // strobe alone selects the bytes that land.
   always_comb begin
      store_strb  = 4'b1111;
      store_wdata = store_data_i;
      unique case (funct3_i[1:0])
         2'b00: begin
            store_strb  = 4'b0001 << addr_i[1:0];
            store_wdata = {4{store_data_i[7:0]}};
         end
         2'b01: begin
            store_strb  = 4'b0011 << addr_i[1:0];
            store_wdata = {2{store_data_i[15:0]}};
         end
         default: begin
            store_strb  = 4'b1111;
            store_wdata = store_data_i;
         end
      endcase
   end

   // Load extract uses the funct3/offset registered at acceptance
   always_comb begin
      load_shifted = dmem_rdata_i >> {offset_q, 3'b000};
      load_ext     = load_shifted;
      unique case (funct3_q)
         3'b000:  load_ext = {{24{load_shifted[7]}}, load_shifted[7:0]};
         3'b001:  load_ext = {{16{load_shifted[15]}}, load_shifted[15:0]};
         3'b100:  load_ext = {24'd0, load_shifted[7:0]};
         3'b101:  load_ext = {16'd0, load_shifted[15:0]};
         default: load_ext = load_shifted;
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d          = state_q;
      dmem_req_valid_d = dmem_req_valid_q;
      dmem_addr_d      = dmem_addr_q;
      dmem_we_d        = dmem_we_q;
      dmem_wstrb_d     = dmem_wstrb_q;
      dmem_wdata_d     = dmem_wdata_q;
      rsp_valid_d      = 1'b0;
      rsp_data_d       = rsp_data_q;
      fault_d          = fault_q;
      funct3_d         = funct3_q;
      offset_d         = offset_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               funct3_d = funct3_i;
               offset_d = addr_i[1:0];
               if (!(is_load || is_store)) begin
                  state_d     = ST_DONE;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = addr_i;
                  fault_d     = 1'b0;
               end else if (req_fault) begin
                  state_d     = ST_DONE;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = '0;
                  fault_d     = 1'b1;
               end else begin
                  state_d          = ST_REQ;
                  dmem_req_valid_d = 1'b1;
                  dmem_addr_d      = {addr_i[AWIDTH-1:2], 2'b00};
                  dmem_we_d        = is_store;
                  dmem_wstrb_d     = is_store ? store_strb : 4'b0000;
                  dmem_wdata_d     = is_store ? store_wdata : '0;
               end
            end
         end
         ST_REQ: begin
            if (dmem_req_ready_i) begin
               dmem_req_valid_d = 1'b0;
               if (dmem_we_q) begin
                  state_d     = ST_DONE;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = '0;
                  fault_d     = 1'b0;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (dmem_rsp_valid_i) begin
               state_d     = ST_DONE;
               rsp_valid_d = 1'b1;
               rsp_data_d  = load_ext;
               fault_d     = 1'b0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            fault_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= ST_IDLE;
         dmem_req_valid_q <= 1'b0;
         dmem_addr_q      <= '0;
         dmem_we_q        <= 1'b0;
         dmem_wstrb_q     <= 4'b0000;
         dmem_wdata_q     <= '0;
         rsp_valid_q      <= 1'b0;
         rsp_data_q       <= '0;
         fault_q          <= 1'b0;
         funct3_q         <= 3'b000;
         offset_q         <= 2'b00;
      end else begin
         state_q          <= state_d;
         dmem_req_valid_q <= dmem_req_valid_d;
         dmem_addr_q      <= dmem_addr_d;
         dmem_we_q        <= dmem_we_d;
         dmem_wstrb_q     <= dmem_wstrb_d;
         dmem_wdata_q     <= dmem_wdata_d;
         rsp_valid_q      <= rsp_valid_d;
         rsp_data_q       <= rsp_data_d;
         fault_q          <= fault_d;
         funct3_q         <= funct3_d;
         offset_q         <= offset_d;
      end
   end

   assign req_ready_o      = (state_q == ST_IDLE);
   assign dmem_req_valid_o = dmem_req_valid_q;
   assign dmem_addr_o      = dmem_addr_q;
   assign dmem_we_o        = dmem_we_q;
   assign dmem_wstrb_o     = dmem_wstrb_q;
   assign dmem_wdata_o     = dmem_wdata_q;
   assign rsp_valid_o      = rsp_valid_q;
   assign rsp_data_o       = rsp_data_q;
   assign fault_o          = fault_q;

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_ALU   = 7'b0110011;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [6:0]  opcode_i = '0;
   logic [2:0]  funct3_i = '0;
   logic [31:0] addr_i = '0;
   logic [31:0] store_data_i = '0;
   logic        dmem_req_valid_o;
   logic        dmem_req_ready_i = 1'b0;
   logic [31:0] dmem_addr_o;
   logic        dmem_we_o;
   logic [3:0]  dmem_wstrb_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_rsp_valid_i = 1'b0;
   logic [31:0] dmem_rdata_i = '0;
   logic        rsp_valid_o;
   logic [31:0] rsp_data_o;
   logic        fault_o;

   memory_access #(.DWIDTH(32), .AWIDTH(32)) dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid_i      (req_valid_i),
      .req_ready_o      (req_ready_o),
      .opcode_i         (opcode_i),
      .funct3_i         (funct3_i),
      .addr_i           (addr_i),
      .store_data_i     (store_data_i),
      .dmem_req_valid_o (dmem_req_valid_o),
      .dmem_req_ready_i (dmem_req_ready_i),
      .dmem_addr_o      (dmem_addr_o),
      .dmem_we_o        (dmem_we_o),
      .dmem_wstrb_o     (dmem_wstrb_o),
      .dmem_wdata_o     (dmem_wdata_o),
      .dmem_rsp_valid_i (dmem_rsp_valid_i),
      .dmem_rdata_i     (dmem_rdata_i),
      .rsp_valid_o      (rsp_valid_o),
      .rsp_data_o       (rsp_data_o),
      .fault_o          (fault_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int hs_count = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { logic [31:0] data; logic fault; } rsp_t;
   typedef struct { logic [31:0] addr; logic we; logic [3:0] strb; logic [31:0] wdata; } mreq_t;
   rsp_t  rsp_q[$];
   mreq_t mreq_q[$];

   function automatic bit m_is_mem(input logic [6:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

   function automatic bit m_fault(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a);
      int nbytes;
      bit legal;
      nbytes = 1 << f3[1:0];
      if (op == OP_LOAD)       legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
      else if (op == OP_STORE) legal = (f3 == 0) || (f3 == 1) || (f3 == 2);
      else                     return 1'b0;
      if (!legal) return 1'b1;
      return (a % nbytes) != 0;
   endfunction

   function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] a);
      int nbytes;
      int s;
      nbytes = 1 << f3[1:0];
      s = ((1 << nbytes) - 1) << a;
      return s[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
      if (f3[1:0] == 2'b00) return 32'h0101_0101 * d[7:0];
      if (f3[1:0] == 2'b01) return 32'h0001_0001 * d[15:0];
      return d;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
      longint span;
      longint v;
      span = 64'd1 << (8 * (1 << f3[1:0]));
      v = (longint'(w) >> (8 * a)) % span;
      if (!f3[2] && (f3[1:0] != 2'b10) && (v >= span / 2)) v = v - span;
      return v[31:0];
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (reset) begin
         if (dmem_req_valid_o) begin
            if (mreq_q.size() == 0) begin
               fail("unexpected dmem request");
            end else begin
               check("dmem addr",  dmem_addr_o,  mreq_q[0].addr);
               check("dmem we",    {31'd0, dmem_we_o}, {31'd0, mreq_q[0].we});
               check("dmem wstrb", {28'd0, dmem_wstrb_o}, {28'd0, mreq_q[0].strb});
               check("dmem wdata", dmem_wdata_o, mreq_q[0].wdata);
               if (dmem_req_ready_i) begin
                  void'(mreq_q.pop_front());
                  hs_count++;
               end
            end
         end
         if (rsp_valid_o) begin
            if (rsp_q.size() == 0) begin
               fail("unexpected rsp_valid_o");
            end else begin
               check("rsp data",  rsp_data_o, rsp_q[0].data);
               check("rsp fault", {31'd0, fault_o}, {31'd0, rsp_q[0].fault});
               void'(rsp_q.pop_front());
            end
         end
      end
   end

   // ---------------- directed transaction driver ----------------
   logic [31:0] last_data;
   logic        last_fault;
   int          req_cycles;
   logic [31:0] seen_addr;
   logic [3:0]  seen_strb;
   logic [31:0] seen_wdata;

   task automatic model_push(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] sd, input logic [31:0] rd, input bit with_rsp);
      rsp_t  r;
      mreq_t m;
      if (!m_is_mem(op)) begin
         r.data = a; r.fault = 1'b0;
      end else if (m_fault(op, f3, a)) begin
         r.data = 32'd0; r.fault = 1'b1;
      end else begin
         m.addr  = a & 32'hFFFF_FFFC;
         m.we    = (op == OP_STORE);
         m.strb  = m.we ? m_strb(f3, a[1:0]) : 4'b0000;
         m.wdata = m.we ? m_wdata(f3, sd) : 32'd0;
         mreq_q.push_back(m);
         r.data  = m.we ? 32'd0 : m_load(f3, a[1:0], rd);
         r.fault = 1'b0;
      end
      if (with_rsp) rsp_q.push_back(r);
   endtask

   task automatic do_txn(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                         input int rdly, input int rspdly);
      int n;
      int exp_lat;
      int k;
      bit mem_go;
      mem_go = m_is_mem(op) && !m_fault(op, f3, a);
      if (!mem_go)           exp_lat = 1;
      else if (op == OP_STORE) exp_lat = 2 + rdly;
      else                   exp_lat = 3 + rdly + rspdly;
      model_push(op, f3, a, sd, rd, 1'b1);
      req_cycles = 0;
      check({name, " ready before"}, {31'd0, req_ready_o}, 32'd1);
      opcode_i = op; funct3_i = f3; addr_i = a; store_data_i = sd; req_valid_i = 1'b1;
      n = cyc;
      tick();
      req_valid_i = 1'b0;
      if (mem_go) begin
         for (int i = 0; i <= rdly; i++) begin
            dmem_req_ready_i = (i == rdly);
            if (dmem_req_valid_o) begin
               req_cycles++;
               seen_addr = dmem_addr_o; seen_strb = dmem_wstrb_o; seen_wdata = dmem_wdata_o;
            end
            tick();
         end
         dmem_req_ready_i = 1'b0;
         if (op == OP_LOAD) begin
            for (int i = 0; i <= rspdly; i++) begin
               dmem_rsp_valid_i = (i == rspdly);
               dmem_rdata_i     = (i == rspdly) ? rd : 32'hDEAD_BEEF;
               tick();
            end
            dmem_rsp_valid_i = 1'b0;
         end
      end
      k = 0;
      while (!rsp_valid_o && k < 20) begin
         tick();
         k++;
      end
      if (!rsp_valid_o) begin
         fail({name, " rsp timeout"});
         rsp_q.delete();
         mreq_q.delete();
      end else begin
         check({name, " latency"}, cyc - n, exp_lat);
         check({name, " ready in done"}, {31'd0, req_ready_o}, 32'd0);
         last_data  = rsp_data_o;
         last_fault = fault_o;
         tick();
         check({name, " rsp one cycle"}, {31'd0, rsp_valid_o}, 32'd0);
         check({name, " ready after"}, {31'd0, req_ready_o}, 32'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      // model pins
      check("model LB",  m_load(3'b000, 2'd0, 32'h8001_F0FF), 32'hFFFF_FFFF);
      check("model LBU", m_load(3'b100, 2'd1, 32'h8001_F0FF), 32'h0000_00F0);
      check("model LH",  m_load(3'b001, 2'd2, 32'h8001_F0FF), 32'hFFFF_8001);
      check("model LW",  m_load(3'b010, 2'd0, 32'h8001_F0FF), 32'h8001_F0FF);
      check("model SB strb", {28'd0, m_strb(3'b000, 2'd3)}, 32'h8);
      check("model SH wdata", m_wdata(3'b001, 32'h0000_BEEF), 32'hBEEF_BEEF);

      // reset state; a request under reset must not be taken
      #1;
      check("rst req_valid", {31'd0, dmem_req_valid_o}, 32'd0);
      check("rst we",        {31'd0, dmem_we_o}, 32'd0);
      check("rst wstrb",     {28'd0, dmem_wstrb_o}, 32'd0);
      check("rst addr",      dmem_addr_o, 32'd0);
      check("rst wdata",     dmem_wdata_o, 32'd0);
      check("rst rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
      check("rst rsp_data",  rsp_data_o, 32'd0);
      check("rst fault",     {31'd0, fault_o}, 32'd0);
      check("rst ready",     {31'd0, req_ready_o}, 32'd1);
      opcode_i = OP_ALU; addr_i = 32'h55; req_valid_i = 1'b1;
      tick();
      tick();
      check("no accept in reset", {31'd0, rsp_valid_o}, 32'd0);
      req_valid_i = 1'b0;
      reset = 1'b1;
      tick();

      // passthrough
      do_txn("passthrough", OP_ALU, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 0, 0);
      check("passthrough data",  last_data, 32'h0000_1234);
      check("passthrough fault", {31'd0, last_fault}, 32'd0);

      // store byte with two stall cycles
      do_txn("sb", OP_STORE, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 2, 0);
      check("sb req cycles", req_cycles, 3);
      check("sb addr",  seen_addr, 32'h0000_0100);
      check("sb strb",  {28'd0, seen_strb}, 32'h8);
      check("sb wdata", seen_wdata, 32'hA5A5_A5A5);
      check("sb data",  last_data, 32'd0);

      // halfword store upper half, word store
      do_txn("sh", OP_STORE, 3'b001, 32'h0000_0202, 32'h1234_BEEF, 32'h0, 0, 0);
      check("sh strb",  {28'd0, seen_strb}, 32'hC);
      check("sh wdata", seen_wdata, 32'hBEEF_BEEF);
      do_txn("sw", OP_STORE, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'h0, 1, 0);

      // loads
      do_txn("lb",  OP_LOAD, 3'b000, 32'h0000_0200, 32'h0, 32'h8001_F0FF, 0, 1);
      check("lb data", last_data, 32'hFFFF_FFFF);
      do_txn("lbu", OP_LOAD, 3'b100, 32'h0000_0201, 32'h0, 32'h8001_F0FF, 0, 4);
      check("lbu data", last_data, 32'h0000_00F0);
      do_txn("lh",  OP_LOAD, 3'b001, 32'h0000_0202, 32'h0, 32'h8001_F0FF, 1, 0);
      check("lh data", last_data, 32'hFFFF_8001);
      do_txn("lw",  OP_LOAD, 3'b010, 32'h0000_0200, 32'h0, 32'h8001_F0FF, 0, 0);
      check("lw data", last_data, 32'h8001_F0FF);
      do_txn("lhu", OP_LOAD, 3'b101, 32'h0000_0206, 32'h0, 32'h8001_F0FF, 0, 2);
      check("lhu data", last_data, 32'h0000_8001);

      // faults (compare process flags any dmem request)
      do_txn("lw misaligned", OP_LOAD, 3'b010, 32'h0000_0102, 32'h0, 32'h0, 0, 0);
      check("lw misaligned fault", {31'd0, last_fault}, 32'd1);
      check("lw misaligned data", last_data, 32'd0);
      do_txn("ld f3 011", OP_LOAD, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0, 0);
      check("ld f3 011 fault", {31'd0, last_fault}, 32'd1);
      do_txn("sh odd", OP_STORE, 3'b001, 32'h0000_0101, 32'h0, 32'h0, 0, 0);
      check("sh odd fault", {31'd0, last_fault}, 32'd1);
      do_txn("st f3 100", OP_STORE, 3'b100, 32'h0000_0100, 32'h0, 32'h0, 0, 0);
      check("st f3 100 fault", {31'd0, last_fault}, 32'd1);

      // reset in REQ: dmem_req_valid_o drops asynchronously
      model_push(OP_STORE, 3'b010, 32'h0000_0500, 32'h1111_2222, 32'h0, 1'b0);
      opcode_i = OP_STORE; funct3_i = 3'b010; addr_i = 32'h500; store_data_i = 32'h1111_2222;
      req_valid_i = 1'b1;
      tick();
      req_valid_i = 1'b0;
      check("req before reset", {31'd0, dmem_req_valid_o}, 32'd1);
      #2 reset = 1'b0;
      mreq_q.delete();
      rsp_q.delete();
      #1;
      check("async req drop", {31'd0, dmem_req_valid_o}, 32'd0);
      tick();
      reset = 1'b1;
      tick();

      // reset in WAIT, then a late response must be ignored
      model_push(OP_LOAD, 3'b010, 32'h0000_0600, 32'h0, 32'h0, 1'b0);
      opcode_i = OP_LOAD; funct3_i = 3'b010; addr_i = 32'h600; req_valid_i = 1'b1;
      tick();
      req_valid_i = 1'b0;
      dmem_req_ready_i = 1'b1;
      tick();
      dmem_req_ready_i = 1'b0;
      reset = 1'b0;
      mreq_q.delete();
      rsp_q.delete();
      #1;
      check("wait reset rsp", {31'd0, rsp_valid_o}, 32'd0);
      check("wait reset ready", {31'd0, req_ready_o}, 32'd1);
      tick();
      reset = 1'b1;
      tick();
      dmem_rsp_valid_i = 1'b1;
      dmem_rdata_i = 32'h1234_5678;
      tick();
      dmem_rsp_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("late rsp ignored", {31'd0, rsp_valid_o}, 32'd0);
         tick();
      end
      do_txn("after reset", OP_LOAD, 3'b010, 32'h0000_0700, 32'h0, 32'h0BAD_F00D, 0, 0);
      check("after reset data", last_data, 32'h0BAD_F00D);

      // back-to-back word stores with req_valid_i held
      begin
         int hs0;
         model_push(OP_STORE, 3'b010, 32'h0000_0300, 32'h1111_1111, 32'h0, 1'b1);
         model_push(OP_STORE, 3'b010, 32'h0000_0304, 32'h2222_2222, 32'h0, 1'b1);
         hs0 = hs_count;
         opcode_i = OP_STORE; funct3_i = 3'b010; addr_i = 32'h300; store_data_i = 32'h1111_1111;
         req_valid_i = 1'b1;
         dmem_req_ready_i = 1'b1;
         for (int i = 0; i < 6; i++) begin
            check("b2b ready", {31'd0, req_ready_o}, (i % 3 == 0) ? 32'd1 : 32'd0);
            check("b2b rsp",   {31'd0, rsp_valid_o}, (i % 3 == 2) ? 32'd1 : 32'd0);
            if (i == 1) begin
               addr_i = 32'h304;
               store_data_i = 32'h2222_2222;
            end
            tick();
            if (i == 3) req_valid_i = 1'b0;
         end
         dmem_req_ready_i = 1'b0;
         check("b2b handshakes", hs_count - hs0, 2);
         check("b2b queue drained", rsp_q.size() + mreq_q.size(), 0);
      end

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
